// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: shared sizing helper for the debounce stability counter.
package input_debouncer_pkg;
  function automatic int cnt_width(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction
endpackage

// File: rtl/input_debouncer_debounce_channel.sv
// debounce_channel: one bit of 2-flop sync, tick-qualified stability counter, clean level and edge strobes.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = 4,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw_in,
  output logic clean_out,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic r_sync1, r_sync2, r_clean, r_rise, r_fall;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_accept;
  assign w_diff    = r_sync2 != r_clean;
  assign w_accept  = w_diff && tick && r_cnt == LAST;
  assign clean_out = r_clean;
  assign rise      = r_rise;
  assign fall      = r_fall;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
      r_clean <= RESET_LEVEL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
      r_clean <= w_accept ? r_sync2 : r_clean;
      r_cnt   <= (!w_diff || w_accept) ? '0 : tick ? r_cnt + 1'b1 : r_cnt;
      r_rise  <= w_accept && r_sync2;
      r_fall  <= w_accept && !r_sync2;
    end
  end
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: NR_OF_BITS independent synchronized, debounced channels with rise/fall strobes.
module input_debouncer #(
  parameter int   NR_OF_BITS   = 2,
  parameter int   STABLE_TICKS = 4,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [NR_OF_BITS-1:0] raw_in,
  output logic [NR_OF_BITS-1:0] clean_out,
  output logic [NR_OF_BITS-1:0] rise,
  output logic [NR_OF_BITS-1:0] fall
);
  for (genvar i = 0; i < NR_OF_BITS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .tick     (tick),
      .raw_in   (raw_in[i]),
      .clean_out(clean_out[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed stimulus pushes expected levels/strobes into queues; a negedge monitor pops and compares.
module tb_input_debouncer;
  typedef struct {
    int         cyc;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;
  localparam int END_CYC = 195;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick;
  logic       tick_mode = 1'b0;
  logic [1:0] raw_in = 2'b11;
  logic [1:0] clean_out, rise, fall;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       lq[$];
  exp_t       sq[$];

  input_debouncer #(.NR_OF_BITS(2), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)) dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .raw_in   (raw_in),
    .clean_out(clean_out),
    .rise     (rise),
    .fall     (fall)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // In gated mode tick is high only on edges whose number is a multiple of 4.
  initial begin
    tick = 1'b1;
    forever begin
      @(negedge clock);
      tick = tick_mode ? ((cyc + 1) % 4 == 0) : 1'b1;
    end
  end

  task automatic push_l(input int c, input logic [1:0] cl, input logic [1:0] r, input logic [1:0] f);
    lq.push_back('{c, cl, r, f});
  endtask

  task automatic push_s(input int c, input logic [1:0] cl, input logic [1:0] r, input logic [1:0] f);
    sq.push_back('{c, cl, r, f});
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  initial begin
    push_l(1, 2'b00, 2'b00, 2'b00);
    push_l(2, 2'b00, 2'b00, 2'b00);
    wait_to(2);  reset = 1'b0;
    push_l(7, 2'b00, 2'b00, 2'b00);
    push_s(8, 2'b11, 2'b11, 2'b00);
    wait_to(10); raw_in = 2'b00;
    push_s(16, 2'b00, 2'b00, 2'b11);
    push_l(17, 2'b00, 2'b00, 2'b00);
    wait_to(20); raw_in = 2'b01;
    push_l(25, 2'b00, 2'b00, 2'b00);
    push_s(26, 2'b01, 2'b01, 2'b00);
    push_l(27, 2'b01, 2'b00, 2'b00);
    wait_to(30); raw_in = 2'b00;
    push_s(36, 2'b00, 2'b00, 2'b01);
    wait_to(40); raw_in = 2'b01;
    wait_to(43); raw_in = 2'b00;
    push_l(48, 2'b00, 2'b00, 2'b00);
    wait_to(50); raw_in = 2'b01;
    push_s(56, 2'b01, 2'b01, 2'b00);
    wait_to(54); raw_in = 2'b00;
    push_l(57, 2'b01, 2'b00, 2'b00);
    push_s(60, 2'b00, 2'b00, 2'b01);
    wait_to(70); raw_in = 2'b01;
    wait_to(73); raw_in = 2'b00;
    wait_to(74); raw_in = 2'b01;
    wait_to(77); raw_in = 2'b00;
    push_l(82, 2'b00, 2'b00, 2'b00);
    wait_to(87); tick_mode = 1'b1;
    wait_to(90); raw_in = 2'b10;
    push_l(107, 2'b00, 2'b00, 2'b00);
    push_s(108, 2'b10, 2'b10, 2'b00);
    wait_to(110); raw_in = 2'b00;
    push_l(127, 2'b10, 2'b00, 2'b00);
    push_s(128, 2'b00, 2'b00, 2'b10);
    wait_to(130); tick_mode = 1'b0;
    wait_to(140); raw_in = 2'b01;
    wait_to(145); reset = 1'b1;
    push_l(146, 2'b00, 2'b00, 2'b00);
    wait_to(146); reset = 1'b0;
    push_l(151, 2'b00, 2'b00, 2'b00);
    push_s(152, 2'b01, 2'b01, 2'b00);
    wait_to(160); raw_in = 2'b00;
    push_s(166, 2'b00, 2'b00, 2'b01);
    wait_to(170); raw_in = 2'b11;
    push_l(175, 2'b00, 2'b00, 2'b00);
    push_s(176, 2'b11, 2'b11, 2'b00);
    push_l(177, 2'b11, 2'b00, 2'b00);
    wait_to(180); raw_in = 2'b00;
    push_s(186, 2'b00, 2'b00, 2'b11);
    push_l(187, 2'b00, 2'b00, 2'b00);
  end

  always @(negedge clock) begin
    exp_t e;
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      e = lq.pop_front();
      checks++;
      if (clean_out !== e.clean || rise !== e.rise || fall !== e.fall) begin
        errors++;
        $display("FAIL level@%0d: got clean=%b rise=%b fall=%b want clean=%b rise=%b fall=%b",
                 cyc, clean_out, rise, fall, e.clean, e.rise, e.fall);
      end
    end
    if ((rise | fall) !== 2'b00) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL strobe@%0d: got unexpected rise=%b fall=%b, want none", cyc, rise, fall);
      end else begin
        e = sq.pop_front();
        if (e.cyc != cyc || clean_out !== e.clean || rise !== e.rise || fall !== e.fall) begin
          errors++;
          $display("FAIL strobe@%0d: got clean=%b rise=%b fall=%b, want cyc=%0d clean=%b rise=%b fall=%b",
                   cyc, clean_out, rise, fall, e.cyc, e.clean, e.rise, e.fall);
        end
      end
    end
    if (cyc == END_CYC) begin
      checks++;
      if (sq.size() != 0 || lq.size() != 0) begin
        errors++;
        $display("FAIL pending: got %0d strobes and %0d levels unseen, want 0 and 0", sq.size(), lq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
endmodule
